cmul_sequencer: RTL and testbench
=================================

# cmul_sequencer

Complex multiply sequencer for the 64-point FFT twiddle stage. It time-shares one instance of the 16x16 fixed-point `multiply` datapath across the four real partial products of a complex multiply, accumulates them, and rounds and saturates the result back to Q1.15. It sits between the butterfly operand fetch and the butterfly adder, with valid/ready handshakes on both sides.

## Interface
- `ROUND`, default 1: 1 = round half up (add 2^14 before the shift); 0 = truncate (arithmetic shift, floor).
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operand set is valid.
- `in_ready`  output  1  block accepts an operand set this cycle.
- `a_re`, `a_im`  input  16 each  data operand, signed Q1.15.
- `b_re`, `b_im`  input  16 each  twiddle operand, signed Q1.15.
- `out_valid`  output  1  result is valid.
- `out_ready`  input  1  downstream consumes the result.
- `out_re`, `out_im`  output  16 each  product a*b, signed Q1.15.
- `sat`  output  1  qualified by `out_valid`; 1 if either component saturated.
- `busy`  output  1  state is not IDLE.

## Operation
- **States:** IDLE, P0, P1, P2, P3, DONE.
- **Accept:** `in_ready` = (state==IDLE) | (state==DONE & `out_ready`). It is combinational from state and `out_ready`.
  - On `in_valid & in_ready`: latch the four operands, clear both accumulators, go to P0.
- **Product phases:** one `multiply` instance. Its inputs are muxed from the latched operands by state:
  - P0: a_re*b_re, added to acc_re.
  - P1: a_im*b_im, subtracted from acc_re.
  - P2: a_re*b_im, added to acc_im.
  - P3: a_im*b_re, added to acc_im.
  - Each phase registers its update at the end of its cycle.
- **Transitions:** P0 -> P1 -> P2 -> P3 -> DONE, one per cycle, unconditional.
- **Width rules:**
  - Each product is 32-bit signed, Q2.30.
  - Accumulators are 33-bit signed. The range is [-2^31, 2^31], so no overflow is possible.
- **Output conversion** (computed on the P3 -> DONE edge from the final accumulator value):
  - If `ROUND`, add 2^14.
  - Arithmetic shift right 15.
  - Saturate to [-32768, 32767].
  - Register into `out_re`/`out_im`. `sat` = OR of both component clip flags.
- **DONE:**
  - `out_valid`=1; `out_re`/`out_im`/`sat` are held stable while `out_ready`=0.
  - On `out_ready`: if `in_valid`, accept the new set and go to P0 (back-to-back); otherwise go to IDLE.
- **Reset (async assert, any state, including mid-product):**
  - state=IDLE, `out_valid`=0, `out_re`=`out_im`=0, `sat`=0, accumulators=0, `busy`=0.
  - `in_ready` reads 1 while in reset.
  - An in-flight operation is discarded and produces no output.
- Operands presented while `in_ready`=0 are ignored. The source must hold them.

## Timing
- Accept edge E0 enters P0. Edges E1..E3 step P1..P3. Edge E4 enters DONE with `out_valid`=1.
- Result is visible 4 cycles after the accept edge.
- Sustained throughput with `out_ready` tied high and `in_valid` continuous: one result per 5 cycles.
- `busy` is high from E0 until the edge that returns to IDLE.
- Output stays registered; no output changes combinationally with inputs except `in_ready`.

## Test plan
- **Basic product:** a=(0x4000,0), b=(0x4000,0) -> `out_re`=0x2000, `out_im`=0x0000, `sat`=0. `out_valid` rises exactly 4 edges after the accept edge.
- **Rounding mode:** a=(0,0x7FFF), b=(0,0x7FFF).
  - `ROUND`=1 -> `out_re`=0x8002 (-32766), `out_im`=0.
  - `ROUND`=0 -> `out_re`=0x8001.
- **Conjugate pair:** a=(0x4000,0x4000), b=(0x4000,0xC000) -> `out_re`=0x4000, `out_im`=0x0000, `sat`=0.
- **Saturation:** a=(0x8000,0), b=(0x8000,0) -> `out_re`=0x7FFF, `out_im`=0, `sat`=1.
- **Backpressure and back-to-back:**
  - Hold `out_ready`=0 for 10 cycles in DONE -> outputs stable, `in_ready`=0.
  - Then assert `out_ready` and `in_valid` in the same cycle -> the result is consumed, the new set is accepted on the same edge, and the next `out_valid` comes 4 edges later.
  - The state never passes through IDLE.
- **Reset mid-operation:** assert `reset_n`=0 asynchronously while in P2 -> `out_valid`=0, `busy`=0, `in_ready`=1 immediately.
  - After release, no stale result appears.
  - A fresh operation completes correctly.

Source files
------------

// File: rtl/cmul_sequencer.sv
// cmul_sequencer: complex multiply (a*b) in Q1.15 that time-shares one 16x16
// signed multiplier across the four real partial products. It accumulates in
// 33 bits, then rounds or truncates and saturates the result back to Q1.15.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A source holds its data and keeps valid high
// until that edge. out_* and sat are registered and stay stable while
// out_valid && !out_ready. in_ready is the only output that depends
// combinationally on an input (out_ready).
module cmul_sequencer #(
  parameter bit ROUND = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] a_re,
  input  logic signed [15:0] a_im,
  input  logic signed [15:0] b_re,
  input  logic signed [15:0] b_im,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_re,
  output logic signed [15:0] out_im,
  output logic               sat,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic signed [15:0] a_re_q, a_im_q, b_re_q, b_im_q;
  logic signed [32:0] acc_re, acc_im;
  logic signed [15:0] mul_x, mul_y;
  logic signed [31:0] prod;
  logic signed [32:0] prod_ext;
  logic signed [32:0] acc_im_fin;
  logic [16:0]        conv_re, conv_im;
  logic               accept;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Round (optional), shift by 15 and saturate to Q1.15. Returns {clip, value}.
  function automatic logic [16:0] convert(input logic signed [32:0] acc);
    logic signed [32:0] r;
    logic signed [32:0] s;
    logic [16:0]        res;
    r = acc + (ROUND ? 33'sd16384 : 33'sd0);
    s = r >>> 15;
    if (s > 33'sd32767)        res = {1'b1, 16'h7FFF};
    else if (s < -33'sd32768)  res = {1'b1, 16'h8000};
    else                       res = {1'b0, s[15:0]};
    return res;
  endfunction

  // Select the multiplier operands for the partial product of this phase.
  always_comb begin
    mul_x = a_re_q;
    mul_y = b_re_q;
    case (state)
      P1:      begin mul_x = a_im_q; mul_y = b_im_q; end
      P2:      begin mul_x = a_re_q; mul_y = b_im_q; end
      P3:      begin mul_x = a_im_q; mul_y = b_re_q; end
      default: begin mul_x = a_re_q; mul_y = b_re_q; end
    endcase
  end

  assign prod       = mul_x * mul_y;
  assign prod_ext   = {prod[31], prod};
  // The imaginary accumulator only becomes final on the P3 edge, so convert
  // its post-update value; acc_re is already final after P1.
  assign acc_im_fin = acc_im + prod_ext;
  assign conv_re    = convert(acc_re);
  assign conv_im    = convert(acc_im_fin);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: fixed four product phases, then wait in DONE for the sink.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = P0;
      P0:      state_nxt = P1;
      P1:      state_nxt = P2;
      P2:      state_nxt = P3;
      P3:      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? P0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, accumulation per phase, and output conversion on P3.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_re_q <= '0;
      a_im_q <= '0;
      b_re_q <= '0;
      b_im_q <= '0;
      acc_re <= '0;
      acc_im <= '0;
      out_re <= '0;
      out_im <= '0;
      sat    <= 1'b0;
    end else begin
      if (accept) begin
        a_re_q <= a_re;
        a_im_q <= a_im;
        b_re_q <= b_re;
        b_im_q <= b_im;
        acc_re <= '0;
        acc_im <= '0;
      end else begin
        case (state)
          P0: acc_re <= acc_re + prod_ext;
          P1: acc_re <= acc_re - prod_ext;
          P2: acc_im <= acc_im + prod_ext;
          P3: begin
            acc_im <= acc_im_fin;
            out_re <= conv_re[15:0];
            out_im <= conv_im[15:0];
            sat    <= conv_re[16] | conv_im[16];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmul_sequencer.sv
// Directed bench for cmul_sequencer. Two instances share every input: u_dut
// rounds (ROUND=1) and u_trn truncates (ROUND=0). Inputs change 1 time unit
// after the rising edge; outputs are sampled at that same point.
module tb_cmul_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P0   = 3'd1;
  localparam logic [2:0] S_P2   = 3'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;

  logic        in_ready, out_valid, sat, busy;
  logic [15:0] out_re, out_im;
  logic [2:0]  dbg_state;
  logic        t_in_ready, t_out_valid, t_sat, t_busy;
  logic [15:0] t_out_re, t_out_im;
  logic [2:0]  t_dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  cmul_sequencer #(.ROUND(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re),
    .out_im(out_im), .sat(sat), .busy(busy), .dbg_state(dbg_state)
  );

  cmul_sequencer #(.ROUND(1'b0)) u_trn (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(t_in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_re(t_out_re),
    .out_im(t_out_im), .sat(t_sat), .busy(t_busy), .dbg_state(t_dbg_state)
  );

  // scoreboard compare point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present an operand set, check it is accepted on the next edge,
  // then return the number of edges until out_valid (bounded at 20).
  task automatic run_op(input logic [15:0] ar, ai, br, bi, output int lat);
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    in_valid = 1'b1;
    chk("in_ready_before_accept", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("state_after_accept", dbg_state, S_P0);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  // driver: consume the current result with no new operands
  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  seen;
    logic [15:0] hold_re, hold_im;

    // reset state
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_re", out_re, 16'h0000);
    chk("rst_sat", sat, 1'b0);
    step();
    reset_n = 1'b1;
    step();

    // basic product: 0.5 * 0.5 = 0.25, latency 4
    run_op(16'h4000, 16'h0000, 16'h4000, 16'h0000, lat);
    chk("basic_latency", lat, 4);
    chk("basic_re", out_re, 16'h2000);
    chk("basic_im", out_im, 16'h0000);
    chk("basic_sat", sat, 1'b0);
    consume();
    chk("basic_back_idle", dbg_state, S_IDLE);
    chk("basic_busy_low", busy, 1'b0);

    // rounding vs truncation: -(0x7FFF^2)
    run_op(16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, lat);
    chk("round_latency", lat, 4);
    chk("round_re", out_re, 16'h8002);
    chk("round_im", out_im, 16'h0000);
    chk("trunc_re", t_out_re, 16'h8001);
    chk("trunc_im", t_out_im, 16'h0000);
    consume();

    // conjugate pair: (0.5+0.5j)(0.5-0.5j) = 0.5
    run_op(16'h4000, 16'h4000, 16'h4000, 16'hC000, lat);
    chk("conj_latency", lat, 4);
    chk("conj_re", out_re, 16'h4000);
    chk("conj_im", out_im, 16'h0000);
    chk("conj_sat", sat, 1'b0);
    consume();

    // saturation: (-1)*(-1) = +1 clips
    run_op(16'h8000, 16'h0000, 16'h8000, 16'h0000, lat);
    chk("sat_latency", lat, 4);
    chk("sat_re", out_re, 16'h7FFF);
    chk("sat_im", out_im, 16'h0000);
    chk("sat_flag", sat, 1'b1);
    chk("sat_trunc_re", t_out_re, 16'h7FFF);
    chk("sat_trunc_flag", t_sat, 1'b1);
    consume();

    // backpressure: (0.25+0.125j)(0.5+0.25j) = 0.09375 + 0.125j
    run_op(16'h2000, 16'h1000, 16'h4000, 16'h2000, lat);
    chk("bp_latency", lat, 4);
    chk("bp_re", out_re, 16'h0C00);
    chk("bp_im", out_im, 16'h1000);
    hold_re = out_re;
    hold_im = out_im;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_re", out_re, 16'h0C00);
      chk("bp_hold_im", out_im, 16'h1000);
      chk("bp_in_ready_low", in_ready, 1'b0);
    end
    // back-to-back: consume and accept on the same edge
    a_re = 16'h4000; a_im = 16'h0000; b_re = 16'h4000; b_im = 16'h0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready, 1'b1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_state_p0", dbg_state, S_P0);
    chk("b2b_valid_dropped", out_valid, 1'b0);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 20; c++) begin
      if (!busy) seen = 1'b1;
      step();
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    chk("b2b_never_idle", seen, 1'b0);
    chk("b2b_latency", lat, 4);
    chk("b2b_re", out_re, 16'h2000);
    chk("b2b_im", out_im, 16'h0000);
    consume();

    // reset mid-operation in P2
    a_re = 16'h4000; a_im = 16'h4000; b_re = 16'h4000; b_im = 16'hC000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mid_state_p2", dbg_state, S_P2);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    step();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("mid_no_stale", seen, 1'b0);
    chk("mid_out_re_cleared", out_re, 16'h0000);
    run_op(16'h8000, 16'h0000, 16'h8000, 16'h0000, lat);
    chk("fresh_latency", lat, 4);
    chk("fresh_re", out_re, 16'h7FFF);
    chk("fresh_sat", sat, 1'b1);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
